// File: rtl/regfile_scoreboard.sv
// Integer register file for the ID stage: two bypassed combinational read
// ports, one write port from WB, and a per-register pending-write scoreboard
// that raises stall while a source operand's producer has not written back.
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic                  rs1_use,
  input  logic                  rs2_use,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  input  logic                  issue_en,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic                  flush,
  output logic                  stall
);

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] regs_q [NREG];
  logic [CNT_WIDTH-1:0]  cnt_q  [NREG];
  logic [CNT_WIDTH-1:0]  cnt_d  [NREG];

  logic wb_hit1, wb_hit2;
  logic busy1, busy2;

  assign wb_hit1 = wb_en && (wb_rd == rs1_addr);
  assign wb_hit2 = wb_en && (wb_rd == rs2_addr);

  // Read ports: x0 reads zero, an arriving write-back is forwarded, else storage.
  always_comb begin
    rs1_data = regs_q[rs1_addr];
    rs2_data = regs_q[rs2_addr];
    if (rs1_addr == '0)   rs1_data = '0;
    else if (wb_hit1)     rs1_data = wb_data;
    if (rs2_addr == '0)   rs2_data = '0;
    else if (wb_hit2)     rs2_data = wb_data;
  end

  // Busy unless the only outstanding write is the one arriving this cycle
  // (bypass already supplies that value). x0 counter is always zero.
  always_comb begin
    busy1 = (cnt_q[rs1_addr] != '0) && !((cnt_q[rs1_addr] == CNT_ONE) && wb_hit1);
    busy2 = (cnt_q[rs2_addr] != '0) && !((cnt_q[rs2_addr] == CNT_ONE) && wb_hit2);
    stall = (rs1_use && busy1) || (rs2_use && busy2);
  end

  // Scoreboard next state: flush clears, otherwise saturating inc / dec per register.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      logic inc, dec;
      cnt_d[r] = cnt_q[r];
      inc = issue_en && !stall && !flush && (issue_rd == ADDR_WIDTH'(r)) && (r != 0);
      dec = wb_en && (wb_rd == ADDR_WIDTH'(r)) && (cnt_q[r] != '0);
      if (flush) begin
        cnt_d[r] = '0;
      end else if (inc && !dec) begin
        if (cnt_q[r] != CNT_MAX) cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (dec && !inc) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
  end

  // Register storage; writes to x0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
    end else if (wb_en && (wb_rd != '0)) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  // Pending-write counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_use, rs2_use;
  logic [31:0] rs1_data, rs2_data;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic        flush;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  // Behavioural model: architectural values and number of outstanding writers.
  logic [31:0] mreg [32];
  int          mpend [32];

  regfile_scoreboard dut (
    .clk(clk), .rst(rst),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_use(rs1_use), .rs2_use(rs2_use),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .flush(flush), .stall(stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wb_en && wb_rd == a) return wb_data;
    return mreg[a];
  endfunction

  // A source must wait if writers are outstanding, unless exactly one is left
  // and it is delivering its value right now.
  function automatic bit must_wait(input logic [4:0] a);
    int left;
    if (a == 0) return 1'b0;
    left = mpend[a];
    if (wb_en && wb_rd == a && left > 0) left = left - 1;
    return left > 0;
  endfunction

  function automatic bit exp_stall();
    return (rs1_use && must_wait(rs1_addr)) || (rs2_use && must_wait(rs2_addr));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at the clock edge, from inputs as they stand before the edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin mreg[r] = 32'h0; mpend[r] = 0; end
    end else begin
      bit st;
      st = exp_stall();
      if (flush) begin
        for (int r = 0; r < 32; r++) mpend[r] = 0;
      end else begin
        int p [32];
        for (int r = 0; r < 32; r++) p[r] = mpend[r];
        if (wb_en && p[wb_rd] > 0) p[wb_rd] = p[wb_rd] - 1;
        if (issue_en && !st && issue_rd != 0) begin
          if (mpend[issue_rd] == 3 && !(wb_en && wb_rd == issue_rd)) p[issue_rd] = 3;
          else p[issue_rd] = p[issue_rd] + 1;
        end
        for (int r = 0; r < 32; r++) mpend[r] = p[r];
      end
      if (wb_en && wb_rd != 0) mreg[wb_rd] = wb_data;
    end
  end

  // Compare process: combinational outputs vs model, every cycle after reset.
  always @(negedge clk) begin
    #3;
    if (check_en) begin
      chk("model_rs1_data", rs1_data, exp_read(rs1_addr));
      chk("model_rs2_data", rs2_data, exp_read(rs2_addr));
      chk("model_stall", {31'h0, stall}, {31'h0, exp_stall()});
    end
  end

  task automatic idle();
    wb_en = 0; wb_rd = 0; wb_data = 0;
    rs1_addr = 0; rs2_addr = 0; rs1_use = 0; rs2_use = 0;
    issue_en = 0; issue_rd = 0; flush = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 0;
    check_en = 1;

    // Reset: every register reads zero with no stall.
    for (int i = 0; i < 32; i++) begin
      if (i != 0) cyc();
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i); rs1_use = 1; rs2_use = 1;
      #3;
      chk("reset_rs1", rs1_data, 32'h0);
      chk("reset_rs2", rs2_data, 32'h0);
      chk("reset_stall", {31'h0, stall}, 32'h0);
    end

    // Write-then-read with bypass, then from storage.
    cyc(); wb_en = 1; wb_rd = 5; wb_data = 32'hDEADBEEF; rs1_addr = 5;
    #3; chk("bypass_x5", rs1_data, 32'hDEADBEEF);
    cyc(); rs1_addr = 5;
    #3; chk("stored_x5", rs1_data, 32'hDEADBEEF);

    // x0: write dropped, issue ignored.
    cyc(); wb_en = 1; wb_rd = 0; wb_data = 32'h12345678; issue_en = 1; issue_rd = 0;
    rs1_addr = 0; rs1_use = 1;
    #3; chk("x0_read_same", rs1_data, 32'h0); chk("x0_stall_same", {31'h0, stall}, 32'h0);
    cyc(); rs1_addr = 0; rs1_use = 1;
    #3; chk("x0_read_next", rs1_data, 32'h0); chk("x0_stall_next", {31'h0, stall}, 32'h0);

    // RAW stall on x7, released by the arriving write-back.
    cyc(); issue_en = 1; issue_rd = 7;
    cyc(); rs1_addr = 7; rs1_use = 1;
    #3; chk("raw_stall", {31'h0, stall}, 32'h1);
    cyc(); rs1_addr = 7; rs1_use = 1; wb_en = 1; wb_rd = 7; wb_data = 32'h55;
    #3; chk("raw_release", {31'h0, stall}, 32'h0); chk("raw_data", rs1_data, 32'h55);

    // Two writers in flight on x3.
    cyc(); issue_en = 1; issue_rd = 3;
    cyc(); issue_en = 1; issue_rd = 3;
    cyc(); rs2_addr = 3; rs2_use = 1; wb_en = 1; wb_rd = 3; wb_data = 32'h1;
    #3; chk("dbl_first_wb_stall", {31'h0, stall}, 32'h1);
    cyc(); rs2_addr = 3; rs2_use = 1; wb_en = 1; wb_rd = 3; wb_data = 32'h2;
    #3; chk("dbl_second_wb_stall", {31'h0, stall}, 32'h0); chk("dbl_data", rs2_data, 32'h2);

    // Flush discards x9 pending and the same-cycle issue of x10.
    cyc(); issue_en = 1; issue_rd = 9;
    cyc(); flush = 1; issue_en = 1; issue_rd = 10;
    cyc(); rs1_addr = 9; rs2_addr = 10; rs1_use = 1; rs2_use = 1;
    #3; chk("flush_stall", {31'h0, stall}, 32'h0);
    cyc(); wb_en = 1; wb_rd = 9; wb_data = 32'hAA;
    cyc(); rs1_addr = 9; rs1_use = 1;
    #3; chk("flush_late_wb_data", rs1_data, 32'hAA); chk("flush_late_wb_stall", {31'h0, stall}, 32'h0);

    // Saturation: four issues to x4 leave count 3.
    for (int k = 0; k < 4; k++) begin cyc(); issue_en = 1; issue_rd = 4; end
    cyc(); wb_en = 1; wb_rd = 4; wb_data = 32'h41;
    cyc(); wb_en = 1; wb_rd = 4; wb_data = 32'h42; rs1_addr = 4; rs1_use = 1;
    #3; chk("sat_second_wb_stall", {31'h0, stall}, 32'h1);
    cyc(); wb_en = 1; wb_rd = 4; wb_data = 32'h43; rs1_addr = 4; rs1_use = 1;
    #3; chk("sat_third_wb_stall", {31'h0, stall}, 32'h0); chk("sat_data", rs1_data, 32'h43);

    // Issue while stalled is ignored.
    cyc(); issue_en = 1; issue_rd = 6;
    cyc(); rs1_addr = 6; rs1_use = 1; issue_en = 1; issue_rd = 12;
    #3; chk("stalled_issue_stall", {31'h0, stall}, 32'h1);
    cyc(); rs2_addr = 12; rs2_use = 1;
    #3; chk("stalled_issue_dropped", {31'h0, stall}, 32'h0);
    cyc(); flush = 1;

    // Randomized traffic on a narrow address range to force collisions.
    for (int n = 0; n < 3000; n++) begin
      cyc();
      wb_en    = ($urandom_range(0, 2) != 0);
      wb_rd    = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 7));
      rs1_use  = 1'($urandom_range(0, 1));
      rs2_use  = 1'($urandom_range(0, 1));
      issue_en = ($urandom_range(0, 2) != 0);
      issue_rd = 5'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 49) == 0);
      if (n % 97 == 96) begin
        rs1_addr = 5'($urandom_range(8, 31));
        wb_rd    = rs1_addr;
      end
    end

    cyc();
    @(negedge clk); #4;
    check_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
